mem_wb_stage: RTL

- Pipeline register between the MEM stage and the integer register file.
- Captures MEM-stage results and selects the writeback source, including load byte/half extraction with sign or zero extension.
- Drives the register file write port: write enable, destination index and write data.
- Also exports the writeback value for the forwarding/hazard logic.

---
 rtl/mem_wb_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback source selection.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_m,
  input  logic            reg_write_m,
  input  logic [1:0]      result_src_m,
  input  logic [2:0]      funct3_m,
  input  logic [4:0]      rd_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] read_data_m,
  input  logic [XLEN-1:0] pc_plus4_m,
  input  logic [XLEN-1:0] imm_m,
  output logic            rf_write_en,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_write_data,
  output logic            valid_w,
  output logic [4:0]      fwd_rd_w,
  output logic [XLEN-1:0] fwd_data_w
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  logic            valid_r;
  logic            reg_write_r;
  logic [1:0]      result_src_r;
  logic [2:0]      funct3_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] alu_result_r;
  logic [XLEN-1:0] read_data_r;
  logic [XLEN-1:0] pc_plus4_r;
  logic [XLEN-1:0] imm_r;

  logic [XLEN-1:0] load_data_s;
  logic [XLEN-1:0] wb_data_s;
  logic            write_en_s;

  // Byte/half lane select from the low address bits, then sign or zero extend.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Pipeline register: rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r      <= 1'b0;
      reg_write_r  <= 1'b0;
      result_src_r <= 2'b00;
      funct3_r     <= 3'b000;
      rd_r         <= 5'd0;
      alu_result_r <= {XLEN{1'b0}};
      read_data_r  <= {XLEN{1'b0}};
      pc_plus4_r   <= {XLEN{1'b0}};
      imm_r        <= {XLEN{1'b0}};
    end else if (!stall) begin
      valid_r      <= valid_m;
      reg_write_r  <= reg_write_m;
      result_src_r <= result_src_m;
      funct3_r     <= funct3_m;
      rd_r         <= rd_m;
      alu_result_r <= alu_result_m;
      read_data_r  <= read_data_m;
      pc_plus4_r   <= pc_plus4_m;
      imm_r        <= imm_m;
    end
  end

  // Writeback source selection from the registered fields.
  always_comb begin
    load_data_s = load_extract(funct3_r, alu_result_r[1:0], read_data_r);
    case (result_src_r)
      2'b00:   wb_data_s = alu_result_r;
      2'b01:   wb_data_s = load_data_s;
      2'b10:   wb_data_s = pc_plus4_r;
      2'b11:   wb_data_s = imm_r;
      default: wb_data_s = alu_result_r;
    endcase
    if (valid_r && reg_write_r && (rd_r != 5'd0)) begin
      write_en_s = 1'b1;
    end else begin
      write_en_s = 1'b0;
    end
  end

  // A stalled valid instruction keeps writing the same value every cycle.
  assign rf_write_en   = write_en_s;
  assign rf_a3         = rd_r;
  assign rf_write_data = wb_data_s;
  assign valid_w       = valid_r;
  assign fwd_rd_w      = write_en_s ? rd_r : 5'd0;
  assign fwd_data_w    = wb_data_s;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_r;

  // Count an instruction when it leaves WB; a stalled one is counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_r <= 64'd0;
    end else if (valid_r && !stall) begin
      instret_r <= instret_r + 64'd1;
    end
  end

  assign instret = instret_r;
`endif

endmodule
